// File: rtl/phoenix_vc_buffer.sv
// Phoenix router input buffer: NUM_VC credit-managed FIFOs, round-robin packet sender.
// Define PHOENIX_VC_BUF_STATS_EN to enable the completed-packet counter on pkt_count.
module phoenix_vc_buffer #(
  parameter int FLIT_W = 16,
  parameter int DEPTH  = 4,
  parameter int NUM_VC = 2,
  localparam int VC_W  = (NUM_VC > 1) ? $clog2(NUM_VC) : 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              rx,
  input  logic [VC_W-1:0]   rx_vc,
  input  logic [FLIT_W-1:0] data_in,
  output logic [NUM_VC-1:0] credit_o,
  output logic              h,
  input  logic              ack_h,
  output logic              data_av,
  output logic [FLIT_W-1:0] data,
  input  logic              data_ack,
  output logic              sender,
  output logic [VC_W-1:0]   active_vc,
  output logic [15:0]       pkt_count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_SEND
  } state_t;

  logic [FLIT_W-1:0] mem_q [NUM_VC][DEPTH];
  logic [PW-1:0]     wr_q  [NUM_VC];
  logic [PW-1:0]     rd_q  [NUM_VC];
  logic [CW-1:0]     cnt_q [NUM_VC];

  state_t            state_q;
  logic [VC_W-1:0]   avc_q;
  logic [VC_W-1:0]   rr_q;
  logic [1:0]        idx_q;
  logic [FLIT_W-1:0] rem_q;

  logic [NUM_VC-1:0] full;
  logic [NUM_VC-1:0] nempty;
  logic [NUM_VC-1:0] pull;
  logic [NUM_VC-1:0] push;
  logic              pull_any;
  logic              pkt_end;
  logic              sel_ok;
  logic [VC_W-1:0]   sel_vc;
  logic [VC_W-1:0]   nxt_vc;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Per-VC occupancy flags, pull/push qualification.
  always_comb begin
    full   = '0;
    nempty = '0;
    pull   = '0;
    push   = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      full[v]   = (cnt_q[v] == CW'(DEPTH));
      nempty[v] = (cnt_q[v] != '0);
      pull[v]   = (state_q == S_SEND) && (avc_q == VC_W'(v))
                  && data_ack && nempty[v];
      push[v]   = rx && (int'(rx_vc) == v) && (!full[v] || pull[v]);
    end
  end

  assign pull_any  = |pull;
  assign credit_o  = ~full | pull;
  assign h         = (state_q == S_REQ);
  assign sender    = (state_q == S_SEND);
  assign data_av   = sender && nempty[avc_q];
  assign data      = mem_q[avc_q][rd_q[avc_q]];
  assign active_vc = avc_q;

  assign pkt_end = pull_any &&
                   (((idx_q == 2'd1) && (data == '0)) ||
                    ((idx_q == 2'd2) && (rem_q == FLIT_W'(1))));

  assign nxt_vc = (avc_q == VC_W'(NUM_VC - 1)) ? '0 : avc_q + 1'b1;

  // Round-robin pick: first non-empty VC at or after rr_q.
  always_comb begin
    sel_ok = 1'b0;
    sel_vc = '0;
    for (int i = 0; i < NUM_VC; i++) begin
      if (!sel_ok && nempty[(int'(rr_q) + i) % NUM_VC]) begin
        sel_ok = 1'b1;
        sel_vc = VC_W'((int'(rr_q) + i) % NUM_VC);
      end
    end
  end

  // VC FIFO storage, pointers and occupancy counts.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int v = 0; v < NUM_VC; v++) begin
        wr_q[v]  <= '0;
        rd_q[v]  <= '0;
        cnt_q[v] <= '0;
      end
    end else begin
      for (int v = 0; v < NUM_VC; v++) begin
        if (push[v]) begin
          mem_q[v][wr_q[v]] <= data_in;
          wr_q[v] <= ptr_inc(wr_q[v]);
        end
        if (pull[v])
          rd_q[v] <= ptr_inc(rd_q[v]);
        if (push[v] && !pull[v])
          cnt_q[v] <= cnt_q[v] + 1'b1;
        else if (!push[v] && pull[v])
          cnt_q[v] <= cnt_q[v] - 1'b1;
      end
    end
  end

  // Packet sequencer: select VC, request route, stream whole packet.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      avc_q   <= '0;
      rr_q    <= '0;
      idx_q   <= '0;
      rem_q   <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (sel_ok) begin
            avc_q   <= sel_vc;
            idx_q   <= '0;
            state_q <= S_REQ;
          end
        end
        S_REQ: begin
          if (ack_h)
            state_q <= S_SEND;
        end
        S_SEND: begin
          if (pull_any) begin
            if (idx_q == 2'd0) begin
              idx_q <= 2'd1;
            end else if (idx_q == 2'd1) begin
              rem_q <= data;
              idx_q <= 2'd2;
            end else begin
              rem_q <= rem_q - 1'b1;
            end
          end
          if (pkt_end) begin
            state_q <= S_IDLE;
            rr_q    <= nxt_vc;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef PHOENIX_VC_BUF_STATS_EN
  logic [15:0] pkt_q;

  // Completed-packet counter, wraps at 16 bits.
  always_ff @(posedge clock) begin
    if (reset)
      pkt_q <= '0;
    else if (pkt_end)
      pkt_q <= pkt_q + 1'b1;
  end

  assign pkt_count = pkt_q;
`else
  assign pkt_count = '0;
`endif

endmodule

// File: tb/tb_phoenix_vc_buffer.sv
// Randomized and directed bench for phoenix_vc_buffer.
// Expected values come from a queue-level packet model of the buffer.
module tb_phoenix_vc_buffer;

  localparam int W  = 16;
  localparam int D  = 4;
  localparam int NV = 2;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          rx = 1'b0;
  logic [0:0]    rx_vc = '0;
  logic [W-1:0]  data_in = '0;
  logic          ack_h = 1'b0;
  logic          data_ack = 1'b0;
  logic [NV-1:0] credit_o;
  logic          h;
  logic          data_av;
  logic [W-1:0]  data;
  logic          sender;
  logic [0:0]    active_vc;
  logic [15:0]   pkt_count;

  phoenix_vc_buffer #(.FLIT_W(W), .DEPTH(D), .NUM_VC(NV)) dut (
    .clock(clock), .reset(reset), .rx(rx), .rx_vc(rx_vc),
    .data_in(data_in), .credit_o(credit_o), .h(h), .ack_h(ack_h),
    .data_av(data_av), .data(data), .data_ack(data_ack),
    .sender(sender), .active_vc(active_vc), .pkt_count(pkt_count)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // model: per-VC flit queues plus packet progress
  logic [W-1:0] mq [NV][D+1];
  int msz [NV];
  int ph;   // 0 idle, 1 requesting, 2 sending
  int cur, rr, n, tot, pk;

  function automatic void mclear();
    for (int v = 0; v < NV; v++) msz[v] = 0;
    ph = 0; cur = 0; rr = 0; n = 0; tot = 0; pk = 0;
  endfunction

  function automatic logic [31:0] exp_pk();
`ifdef PHOENIX_VC_BUF_STATS_EN
    return 32'(pk & 16'hffff);
`else
    return 32'd0;
`endif
  endfunction

  function automatic bool_idle();
    return (ph == 0) && (msz[0] == 0) && (msz[1] == 0);
  endfunction

  task automatic cyc(input bit r, input int vc, input logic [W-1:0] d,
                     input bit ah, input bit da);
    bit pl;
    bit acc;
    int sel;
    logic [W-1:0] f;
    @(negedge clock);
    rx = r; rx_vc = vc[0:0]; data_in = d; ack_h = ah; data_ack = da;
    #1;
    pl = (ph == 2) && (msz[cur] > 0) && da;
    check("h", 32'(h), 32'(ph == 1));
    check("sender", 32'(sender), 32'(ph == 2));
    check("data_av", 32'(data_av), 32'((ph == 2) && (msz[cur] > 0)));
    if ((ph == 2) && (msz[cur] > 0))
      check("data", 32'(data), 32'(mq[cur][0]));
    if (ph != 0)
      check("active_vc", 32'(active_vc), 32'(cur));
    for (int v = 0; v < NV; v++)
      check("credit", 32'(credit_o[v]),
            32'((msz[v] != D) || (pl && cur == v)));
    check("pkt_count", 32'(pkt_count), exp_pk());
    acc = r && (vc < NV) && ((msz[vc] < D) || (pl && cur == vc));
    sel = -1;
    if (ph == 0)
      for (int i = 0; i < NV; i++)
        if (sel < 0 && msz[(rr + i) % NV] > 0) sel = (rr + i) % NV;
    if (pl) begin
      f = mq[cur][0];
      for (int k = 0; k < D; k++) mq[cur][k] = mq[cur][k+1];
      msz[cur]--;
      n++;
      if (n == 2) tot = int'(f) + 2;
      if (n >= 2 && n == tot) begin
        ph = 0; rr = (cur + 1) % NV; pk++;
      end
    end else if (ph == 1 && ah) begin
      ph = 2;
    end else if (ph == 0 && sel >= 0) begin
      cur = sel; ph = 1; n = 0;
    end
    if (acc) begin
      mq[vc][msz[vc]] = d;
      msz[vc]++;
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1; rx = 1'b0; ack_h = 1'b0; data_ack = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    mclear();
    #1;
    check("rst_credit", 32'(credit_o), 32'h3);
    check("rst_h", 32'(h), 32'd0);
    check("rst_sender", 32'(sender), 32'd0);
    check("rst_data_av", 32'(data_av), 32'd0);
    check("rst_pkt", 32'(pkt_count), 32'd0);
    check("rst_avc", 32'(active_vc), 32'd0);
  endtask

  task automatic drain();
    int k;
    for (k = 0; k < 300; k++) begin
      if (bool_idle()) break;
      cyc(0, 0, '0, 1'b1, 1'b1);
    end
    check("drain_done", 32'(k < 300), 32'd1);
  endtask

  int gpos [NV];
  int gsz  [NV];

  function automatic logic [W-1:0] gen_flit(input int v);
    logic [W-1:0] f;
    if (gpos[v] == 0) begin
      f = W'(16'h8000 | (v << 12) | $urandom_range(0, 4095));
    end else if (gpos[v] == 1) begin
      gsz[v] = $urandom_range(0, 3);
      f = W'(gsz[v]);
    end else begin
      f = W'($urandom);
    end
    gpos[v]++;
    if (gpos[v] >= 2 && gpos[v] == gsz[v] + 2) gpos[v] = 0;
    return f;
  endfunction

  initial begin
    #2000000;
    $display("FAIL timeout");
    $fatal(1);
  end

  initial begin
    int v;
    mclear();
    // single packet on VC0
    do_reset();
    cyc(1, 0, 16'hA001, 1'b1, 1'b1);
    check("t1_h_c0", 32'(h), 32'd0);
    cyc(1, 0, 16'd2, 1'b1, 1'b1);
    check("t1_h_c1", 32'(h), 32'd0);
    cyc(1, 0, 16'h1111, 1'b1, 1'b1);
    check("t1_h_c2", 32'(h), 32'd1);
    cyc(1, 0, 16'h2222, 1'b1, 1'b1);
    drain();
    cyc(0, 0, '0, 1'b0, 1'b0);
    check("t1_sender", 32'(sender), 32'd0);
    // zero-size packet on VC1
    cyc(1, 1, 16'hB001, 1'b1, 1'b1);
    cyc(1, 1, 16'd0, 1'b1, 1'b1);
    drain();
    cyc(0, 0, '0, 1'b0, 1'b0);
`ifdef PHOENIX_VC_BUF_STATS_EN
    check("t2_pkt", 32'(pkt_count), 32'd2);
`else
    check("t2_pkt", 32'(pkt_count), 32'd0);
`endif
    // full FIFO, dropped push, push+pull on full
    do_reset();
    cyc(1, 0, 16'hC001, 1'b0, 1'b0);
    cyc(1, 0, 16'd2, 1'b0, 1'b0);
    cyc(1, 0, 16'h3333, 1'b0, 1'b0);
    cyc(1, 0, 16'h4444, 1'b0, 1'b0);
    cyc(1, 0, 16'hDEAD, 1'b0, 1'b0);
    check("t3_credit_full", 32'(credit_o), 32'h2);
    cyc(0, 0, '0, 1'b1, 1'b0);
    cyc(1, 0, 16'hC101, 1'b0, 1'b1);
    check("t3_credit_pp", 32'(credit_o[0]), 32'd1);
    check("t3_data_hdr", 32'(data), 32'hC001);
    cyc(0, 0, '0, 1'b0, 1'b0);
    check("t3_still_full", 32'(credit_o[0]), 32'd0);
    cyc(1, 0, 16'd0, 1'b0, 1'b1);
    drain();
    // round robin
    do_reset();
    cyc(1, 0, 16'hE000, 1'b0, 1'b0);
    cyc(1, 1, 16'hE100, 1'b0, 1'b0);
    cyc(1, 0, 16'd0, 1'b0, 1'b0);
    cyc(1, 1, 16'd1, 1'b0, 1'b0);
    cyc(1, 1, 16'h5555, 1'b0, 1'b0);
    check("t4_first_vc", 32'(active_vc), 32'd0);
    check("t4_first_h", 32'(h), 32'd1);
    cyc(0, 0, '0, 1'b1, 1'b1);
    cyc(0, 0, '0, 1'b0, 1'b1);
    cyc(1, 0, 16'hE200, 1'b0, 1'b1);
    cyc(1, 0, 16'd0, 1'b0, 1'b0);
    cyc(0, 0, '0, 1'b0, 1'b0);
    check("t4_second_vc", 32'(active_vc), 32'd1);
    drain();
    // stall mid-payload
    do_reset();
    cyc(1, 0, 16'hF000, 1'b1, 1'b0);
    cyc(1, 0, 16'd3, 1'b1, 1'b0);
    cyc(1, 0, 16'h6001, 1'b1, 1'b0);
    cyc(1, 0, 16'h6002, 1'b1, 1'b0);
    cyc(0, 0, '0, 1'b0, 1'b1);
    cyc(0, 0, '0, 1'b0, 1'b1);
    cyc(1, 0, 16'h6003, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, '0, 1'b0, 1'b0);
      check("t5_hold", 32'(data), 32'h6002);
    end
    drain();
    // reset after 2 of 4 flits
    do_reset();
    cyc(1, 0, 16'h7000, 1'b1, 1'b0);
    cyc(1, 0, 16'd2, 1'b1, 1'b0);
    cyc(1, 0, 16'h7001, 1'b1, 1'b0);
    cyc(1, 0, 16'h7002, 1'b1, 1'b0);
    cyc(0, 0, '0, 1'b0, 1'b1);
    cyc(0, 0, '0, 1'b0, 1'b1);
    do_reset();
    // randomized traffic
    for (int i = 0; i < NV; i++) begin
      gpos[i] = 0; gsz[i] = 0;
    end
    for (int i = 0; i < 3000; i++) begin
      v = int'($urandom_range(0, NV - 1));
      if (msz[v] < D && $urandom_range(0, 9) < 7)
        cyc(1, v, gen_flit(v), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 3) != 0));
      else
        cyc(0, 0, '0, 1'($urandom_range(0, 1)),
            ($urandom_range(0, 3) != 0));
    end
    for (int i = 0; i < NV; i++)
      while (gpos[i] != 0) begin
        if (msz[i] < D) cyc(1, i, gen_flit(i), 1'b1, 1'b1);
        else cyc(0, 0, '0, 1'b1, 1'b1);
      end
    drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
